// File: rtl/lap_det_pkg.sv
// Shared types and constants for the lap marker detector and its neighbours.
package lap_det_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    PULSE   = 2'd2,
    LOCKOUT = 2'd3
  } lap_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_PULSE_CYCLES    = 4;
  localparam int DEF_LOCKOUT_CYCLES  = 50000000;

  // Width needed to hold every value 0..limit, never less than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sensor_sync.sv
// N-bit two-flop synchronizer for asynchronous sensor inputs.
module sensor_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/lap_marker_detector.sv
// Detects the start/finish stripe, debounces it and emits one fixed-width
// lap_pulse per crossing, with a lockout that needs the stripe to be left.
module lap_marker_detector
  import lap_det_pkg::*;
#(
  parameter int N_SENSORS          = 5,
  parameter int MIN_ACTIVE         = 5,
  parameter bit SENSOR_ACTIVE_HIGH = 1'b1,
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES       = DEF_PULSE_CYCLES,
  parameter int LOCKOUT_CYCLES     = DEF_LOCKOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENSORS-1:0] sensors,
  input  logic                 enable,
  output logic                 lap_pulse,
  output logic                 armed,
  output logic                 marker_seen
);

  localparam int POP_W = $clog2(N_SENSORS + 1);
  localparam int DEB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int PUL_W = cnt_width(PULSE_CYCLES);
  localparam int LCK_W = cnt_width(LOCKOUT_CYCLES);

  localparam logic [POP_W-1:0] MIN_POP  = POP_W'(MIN_ACTIVE);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PUL_W-1:0] PUL_LOAD = PUL_W'(PULSE_CYCLES);
  localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(LOCKOUT_CYCLES);
  localparam bit               DEB_ONE  = (DEBOUNCE_CYCLES <= 1);

  logic [N_SENSORS-1:0] sync_s;
  logic [N_SENSORS-1:0] pol_s;
  logic [POP_W-1:0]     pop_s;
  logic                 mark_s;

  lap_state_e       state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [PUL_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lap_pulse_q, lap_pulse_d;
  logic             marker_seen_q;
  logic             live_q;

  sensor_sync #(.WIDTH(N_SENSORS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sensors),
    .q     (sync_s)
  );

  assign pol_s = SENSOR_ACTIVE_HIGH ? sync_s : ~sync_s;

  always_comb begin
    pop_s = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      pop_s = pop_s + POP_W'(pol_s[i]);
    end
  end

  assign mark_s = (pop_s >= MIN_POP);

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    lap_pulse_d = lap_pulse_q;
    case (state_q)
      IDLE: begin
        deb_cnt_d   = '0;
        lap_pulse_d = 1'b0;
        if (enable && mark_s) begin
          if (DEB_ONE) begin
            state_d     = PULSE;
            lap_pulse_d = 1'b1;
            pulse_cnt_d = PUL_LOAD;
          end else begin
            state_d   = CONFIRM;
            deb_cnt_d = DEB_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      CONFIRM: begin
        if (!enable || !mark_s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d     = PULSE;
          deb_cnt_d   = '0;
          lap_pulse_d = 1'b1;
          pulse_cnt_d = PUL_LOAD;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PULSE: begin
        if (pulse_cnt_q <= PUL_W'(1)) begin
          state_d     = LOCKOUT;
          lap_pulse_d = 1'b0;
          pulse_cnt_d = '0;
          lock_cnt_d  = '0;
        end else begin
          lap_pulse_d = 1'b1;
          pulse_cnt_d = pulse_cnt_q - PUL_W'(1);
        end
      end
      LOCKOUT: begin
        lap_pulse_d = 1'b0;
        // Re-arm only once the dwell has expired and the stripe has been left.
        if ((lock_cnt_q == LCK_MAX) && !mark_s) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q != LCK_MAX) begin
          lock_cnt_d = lock_cnt_q + LCK_W'(1);
        end else begin
          lock_cnt_d = lock_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        deb_cnt_d   = '0;
        pulse_cnt_d = '0;
        lock_cnt_d  = '0;
        lap_pulse_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      deb_cnt_q     <= '0;
      pulse_cnt_q   <= '0;
      lock_cnt_q    <= '0;
      lap_pulse_q   <= 1'b0;
      marker_seen_q <= 1'b0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      deb_cnt_q     <= deb_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      lap_pulse_q   <= lap_pulse_d;
      marker_seen_q <= mark_s;
      live_q        <= 1'b1;
    end
  end

  // live_q keeps armed low while reset is held and for the edge it is released on.
  assign armed       = live_q && (state_q == IDLE) && enable;
  assign lap_pulse   = lap_pulse_q;
  assign marker_seen = marker_seen_q;

endmodule
